alu_sequencer: RTL and testbench

Multi-cycle 4-bit arithmetic unit that consumes the operand/opcode triple delivered by the SPI slave receiver and returns `resultado` to it for transmission on MISO. It latches `num1`, `num2` and `operacion` on a `start` pulse. It executes add/sub in one step and mul/div as 4-iteration shift-add and restoring-divide sequences. It then presents a registered result with status flags and a one-cycle `done` pulse.

---
 rtl/alu_sequencer_if.sv | 36 +++
 rtl/alu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
`timescale 1ns/1ps
// alu_sequencer_if
// Groups the operand/opcode request and the result/status return of the
// multi-cycle ALU into one bundle.
//   start      : one-cycle request pulse, operands valid in that cycle
//   num1, num2 : unsigned operands A and B
//   operacion  : opcode (00 add, 01 sub, 10 mul, 11 div)
//   resultado  : registered result, held until the next completion
//   overflow   : carry / borrow / product-overflow flag
//   div_zero   : last completed op was a divide by zero
//   busy       : operation in flight
//   done       : one-cycle completion strobe
// The master side issues requests; the slave side is the ALU.
interface alu_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [1:0]       operacion;
    logic [WIDTH-1:0] resultado;
    logic             overflow;
    logic             div_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, num1, num2, operacion,
        input  resultado, overflow, div_zero, busy, done
    );

    modport slave (
        input  start, num1, num2, operacion,
        output resultado, overflow, div_zero, busy, done
    );
endinterface

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
// alu_sequencer
// Multi-cycle unsigned ALU: add/sub in one step, mul as WIDTH shift-add
// iterations (multiplier LSB first), div as WIDTH restoring-divide
// iterations (dividend MSB first). Results and flags are registered and
// only change on the done edge or on reset.
// Ports:
//   SLCK        : clock, rising edge
//   rst         : asynchronous active-high reset
//   bus         : request/result bundle (slave side)
//   o_dbg_state : current FSM state encoding, for observation only
// Handshake: a request is taken on any rising edge where start=1 and the
// FSM is idle (busy=0); start while busy=1 is dropped, never queued. The
// result is valid in the single cycle where done=1 and stays held after.
// busy and done are never high together, so a new start may be presented
// in the done cycle and is accepted on the next edge.
module alu_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                SLCK,
    input  logic                rst,
    alu_sequencer_if.slave      bus,
    output logic [2:0]          o_dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDSUB = 3'd1,
        S_MUL    = 3'd2,
        S_DIV    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;        // operand A; holds the quotient during div
    logic [WIDTH-1:0]   r_b;        // operand B; shifted right during mul
    logic               r_sub;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_res_stage;
    logic               r_ovf_stage;
    logic               r_dz_stage;
    logic [WIDTH-1:0]   r_resultado;
    logic               r_overflow;
    logic               r_div_zero;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH:0]     w_shift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_last;

    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
    assign w_dif       = {1'b0, r_a} - {1'b0, r_b};   // MSB is the borrow
    assign w_prod_next = r_b[0] ? (r_prod + r_mcand) : r_prod;

    // Restoring divide step: bring in the next dividend bit, subtract the
    // divisor only if it fits. The partial remainder is always < B, so the
    // trial difference is exact in WIDTH bits whenever it is kept.
    assign w_shift     = {r_rem, r_a[WIDTH-1]};
    assign w_fits      = (w_shift >= {1'b0, r_b});
    assign w_sub       = w_shift[WIDTH-1:0] - r_b;
    assign w_rem_next  = w_fits ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_next  = {r_a[WIDTH-2:0], w_fits};
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge SLCK or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_mcand     <= '0;
            r_rem       <= '0;
            r_res_stage <= '0;
            r_ovf_stage <= 1'b0;
            r_dz_stage  <= 1'b0;
            r_resultado <= '0;
            r_overflow  <= 1'b0;
            r_div_zero  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.num1;
                        r_b     <= bus.num2;
                        r_sub   <= (bus.operacion == 2'b01);
                        r_cnt   <= '0;
                        r_prod  <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, bus.num1};
                        r_rem   <= '0;
                        r_busy  <= 1'b1;
                        case (bus.operacion)
                            2'b00, 2'b01: r_state <= S_ADDSUB;
                            2'b10:        r_state <= S_MUL;
                            default: begin
                                if (bus.num2 == '0) begin
                                    r_res_stage <= '1;
                                    r_ovf_stage <= 1'b0;
                                    r_dz_stage  <= 1'b1;
                                    r_state     <= S_FINISH;
                                end else begin
                                    r_state <= S_DIV;
                                end
                            end
                        endcase
                    end
                end
                S_ADDSUB: begin
                    r_res_stage <= r_sub ? w_dif[WIDTH-1:0] : w_sum[WIDTH-1:0];
                    r_ovf_stage <= r_sub ? w_dif[WIDTH] : w_sum[WIDTH];
                    r_dz_stage  <= 1'b0;
                    r_state     <= S_FINISH;
                end
                S_MUL: begin
                    r_prod  <= w_prod_next;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res_stage <= w_prod_next[WIDTH-1:0];
                        r_ovf_stage <= |w_prod_next[2*WIDTH-1:WIDTH];
                        r_dz_stage  <= 1'b0;
                        r_state     <= S_FINISH;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_a   <= w_quo_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res_stage <= w_quo_next;
                        r_ovf_stage <= 1'b0;
                        r_dz_stage  <= 1'b0;
                        r_state     <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_resultado <= r_res_stage;
                    r_overflow  <= r_ovf_stage;
                    r_div_zero  <= r_dz_stage;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.resultado = r_resultado;
    assign bus.overflow  = r_overflow;
    assign bus.div_zero  = r_div_zero;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;
    logic       SLCK;
    logic       rst;
    logic [2:0] dbg_state;
    int         n_checks;
    int         n_errors;

    alu_sequencer_if #(.WIDTH(4)) bus ();

    alu_sequencer #(.WIDTH(4)) dut (
        .SLCK        (SLCK),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        SLCK = 1'b0;
        forever #5 SLCK = ~SLCK;
    end

    // driver: issue one op, wait (bounded) for done, return what was seen.
    // lat = number of edges from the sampling edge T to the done edge, -1 on timeout.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          output int lat, output logic [3:0] res, output logic ovf,
                          output logic dz, output logic bsy);
        @(negedge SLCK);
        bus.num1 = a; bus.num2 = b; bus.operacion = op; bus.start = 1'b1;
        @(posedge SLCK);
        #1;
        bus.start = 1'b0;
        bsy = bus.busy;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge SLCK);
            #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        res = bus.resultado; ovf = bus.overflow; dz = bus.div_zero;
    endtask

    task automatic test_reset();
        @(posedge SLCK);
        #1;
        n_checks++; if (bus.resultado !== 4'd0) begin n_errors++; $display("FAIL reset_resultado: got %0d expected 0", bus.resultado); end
        n_checks++; if ({bus.overflow, bus.div_zero, bus.busy, bus.done} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.overflow, bus.div_zero, bus.busy, bus.done}); end
        n_checks++; if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        @(negedge SLCK);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat; logic [3:0] res; logic ovf, dz, bsy;
        run_op(4'd7, 4'd5, 2'b00, lat, res, ovf, dz, bsy);
        n_checks++; if (bsy !== 1'b1) begin n_errors++; $display("FAIL add1_busy: got %b expected 1", bsy); end
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL add1_lat: got %0d expected 2", lat); end
        n_checks++; if ({ovf, res} !== {1'b0, 4'd12}) begin n_errors++; $display("FAIL add1_res: got ovf=%b res=%0d expected ovf=0 res=12", ovf, res); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL add1_busy_at_done: got %b expected 0", bus.busy); end
        run_op(4'd9, 4'd8, 2'b00, lat, res, ovf, dz, bsy);
        n_checks++; if ({ovf, res} !== {1'b1, 4'd1}) begin n_errors++; $display("FAIL add2_res: got ovf=%b res=%0d expected ovf=1 res=1", ovf, res); end
    endtask

    task automatic test_sub();
        int lat; logic [3:0] res; logic ovf, dz, bsy;
        run_op(4'd3, 4'd5, 2'b01, lat, res, ovf, dz, bsy);
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL sub1_lat: got %0d expected 2", lat); end
        n_checks++; if ({ovf, res} !== {1'b1, 4'd14}) begin n_errors++; $display("FAIL sub1_res: got ovf=%b res=%0d expected ovf=1 res=14", ovf, res); end
        run_op(4'd9, 4'd4, 2'b01, lat, res, ovf, dz, bsy);
        n_checks++; if ({ovf, res} !== {1'b0, 4'd5}) begin n_errors++; $display("FAIL sub2_res: got ovf=%b res=%0d expected ovf=0 res=5", ovf, res); end
    endtask

    task automatic test_mul();
        int lat; logic [3:0] res; logic ovf, dz, bsy;
        run_op(4'd5, 4'd3, 2'b10, lat, res, ovf, dz, bsy);
        n_checks++; if (lat !== 5) begin n_errors++; $display("FAIL mul1_lat: got %0d expected 5", lat); end
        n_checks++; if ({ovf, res} !== {1'b0, 4'd15}) begin n_errors++; $display("FAIL mul1_res: got ovf=%b res=%0d expected ovf=0 res=15", ovf, res); end
        run_op(4'd6, 4'd3, 2'b10, lat, res, ovf, dz, bsy);
        n_checks++; if ({ovf, res} !== {1'b1, 4'd2}) begin n_errors++; $display("FAIL mul2_res: got ovf=%b res=%0d expected ovf=1 res=2", ovf, res); end
        run_op(4'd15, 4'd0, 2'b10, lat, res, ovf, dz, bsy);
        n_checks++; if ({ovf, res} !== {1'b0, 4'd0}) begin n_errors++; $display("FAIL mul3_res: got ovf=%b res=%0d expected ovf=0 res=0", ovf, res); end
    endtask

    task automatic test_div();
        int lat; logic [3:0] res; logic ovf, dz, bsy;
        run_op(4'd13, 4'd4, 2'b11, lat, res, ovf, dz, bsy);
        n_checks++; if (lat !== 5) begin n_errors++; $display("FAIL div1_lat: got %0d expected 5", lat); end
        n_checks++; if ({dz, ovf, res} !== {1'b0, 1'b0, 4'd3}) begin n_errors++; $display("FAIL div1_res: got dz=%b ovf=%b res=%0d expected dz=0 ovf=0 res=3", dz, ovf, res); end
        run_op(4'd7, 4'd0, 2'b11, lat, res, ovf, dz, bsy);
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL divz_lat: got %0d expected 1", lat); end
        n_checks++; if ({dz, ovf, res} !== {1'b1, 1'b0, 4'hF}) begin n_errors++; $display("FAIL divz_res: got dz=%b ovf=%b res=%0d expected dz=1 ovf=0 res=15", dz, ovf, res); end
        run_op(4'd8, 4'd2, 2'b11, lat, res, ovf, dz, bsy);
        n_checks++; if ({dz, ovf, res} !== {1'b0, 1'b0, 4'd4}) begin n_errors++; $display("FAIL div3_res: got dz=%b ovf=%b res=%0d expected dz=0 ovf=0 res=4", dz, ovf, res); end
    endtask

    // start pulsed while a mul is in flight must be dropped
    task automatic test_ignore_start();
        int n_done; int done_at; int both_hi; logic [3:0] res; logic [3:0] held;
        n_done = 0; done_at = -1; both_hi = 0; res = 4'd0;
        @(negedge SLCK);
        bus.num1 = 4'd5; bus.num2 = 4'd3; bus.operacion = 2'b10; bus.start = 1'b1;
        @(posedge SLCK);
        #1;
        bus.num1 = 4'd1; bus.num2 = 4'd1; bus.operacion = 2'b00; bus.start = 1'b0;
        @(posedge SLCK);
        @(negedge SLCK);
        bus.start = 1'b1;
        @(posedge SLCK);
        #1;
        bus.start = 1'b0;
        held = bus.resultado;
        for (int k = 3; k <= 12; k++) begin
            @(posedge SLCK);
            #1;
            if (bus.busy === 1'b1 && bus.done === 1'b1) both_hi++;
            if (bus.done === 1'b1) begin
                n_done++;
                if (done_at < 0) begin done_at = k; res = bus.resultado; end
            end
        end
        n_checks++; if (held !== 4'd4) begin n_errors++; $display("FAIL ign_held: got %0d expected 4", held); end
        n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL ign_done_count: got %0d expected 1", n_done); end
        n_checks++; if (done_at !== 5) begin n_errors++; $display("FAIL ign_lat: got %0d expected 5", done_at); end
        n_checks++; if (res !== 4'd15) begin n_errors++; $display("FAIL ign_res: got %0d expected 15", res); end
        n_checks++; if (both_hi !== 0) begin n_errors++; $display("FAIL ign_busy_done: got %0d expected 0", both_hi); end
    endtask

    // second start is raised inside the done cycle of the first op
    task automatic test_back_to_back();
        int lat; logic [3:0] res; logic ovf, dz, bsy; logic done_now;
        run_op(4'd7, 4'd5, 2'b00, lat, res, ovf, dz, bsy);
        n_checks++; if (res !== 4'd12) begin n_errors++; $display("FAIL b2b_first_res: got %0d expected 12", res); end
        @(negedge SLCK);
        done_now = bus.done;
        bus.num1 = 4'd9; bus.num2 = 4'd4; bus.operacion = 2'b01; bus.start = 1'b1;
        n_checks++; if (done_now !== 1'b1) begin n_errors++; $display("FAIL b2b_in_done_cycle: got %b expected 1", done_now); end
        @(posedge SLCK);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge SLCK);
            #1;
            if (bus.done === 1'b1) begin lat = k; break; end
        end
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL b2b_lat: got %0d expected 2", lat); end
        n_checks++; if ({bus.overflow, bus.resultado} !== {1'b0, 4'd5}) begin n_errors++; $display("FAIL b2b_res: got ovf=%b res=%0d expected ovf=0 res=5", bus.overflow, bus.resultado); end
    endtask

    task automatic test_async_reset();
        int lat; logic [3:0] res; logic ovf, dz, bsy; int dones;
        run_op(4'd7, 4'd0, 2'b11, lat, res, ovf, dz, bsy);   // leaves resultado=F, div_zero=1
        @(negedge SLCK);
        bus.num1 = 4'd13; bus.num2 = 4'd4; bus.operacion = 2'b11; bus.start = 1'b1;
        @(posedge SLCK);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge SLCK);
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.resultado !== 4'd0) begin n_errors++; $display("FAIL arst_resultado: got %0d expected 0", bus.resultado); end
        n_checks++; if ({bus.overflow, bus.div_zero, bus.busy, bus.done} !== 4'b0000) begin n_errors++; $display("FAIL arst_flags: got %b expected 0000", {bus.overflow, bus.div_zero, bus.busy, bus.done}); end
        n_checks++; if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL arst_state: got %0d expected 0", dbg_state); end
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge SLCK);
            #1;
            if (bus.done !== 1'b0) dones++;
        end
        n_checks++; if (dones !== 0) begin n_errors++; $display("FAIL arst_no_done: got %0d expected 0", dones); end
        @(negedge SLCK);
        rst = 1'b0;
        run_op(4'd2, 4'd2, 2'b00, lat, res, ovf, dz, bsy);
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL arst_after_lat: got %0d expected 2", lat); end
        n_checks++; if ({dz, ovf, res} !== {1'b0, 1'b0, 4'd4}) begin n_errors++; $display("FAIL arst_after_res: got dz=%b ovf=%b res=%0d expected dz=0 ovf=0 res=4", dz, ovf, res); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.num1 = 4'd0;
        bus.num2 = 4'd0;
        bus.operacion = 2'b00;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(posedge SLCK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
